// File: rtl/fc_argmax_topk2.sv
// Argmax / top-2 classifier for the FC output stage: scans NUM_CLASSES scores,
// LANES per cycle, and reports winner, runner-up and the confidence margin.
module fc_argmax_topk2 #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int LANES       = 1,
    parameter int SIGNED      = 1,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] arr [0:NUM_CLASSES-1],
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  result,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  second_idx,
    output logic [DATA_W:0]   margin
);

    localparam int BEATS = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int PW    = $clog2(BEATS * LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     base;
    logic [BW-1:0]     beat;
    logic [DATA_W-1:0] best_val, sec_val;
    logic [IDX_W-1:0]  best_idx, sec_idx;
    logic              sec_vld;

    logic [DATA_W-1:0] nb_val, ns_val;
    logic [IDX_W-1:0]  nb_idx, ns_idx;
    logic              ns_vld;
    logic [PW-1:0]     ci;
    logic [DATA_W-1:0] cv;
    logic              last_beat;

    // Scores padded to a power-of-two table so the lane index never reads out of range.
    logic [DATA_W-1:0] padded [0:(2**PW)-1];

    for (genvar g = 0; g < 2**PW; g++) begin : g_pad
        if (g < NUM_CLASSES) begin : g_real
            assign padded[g] = arr[g];
        end else begin : g_zero
            assign padded[g] = '0;
        end
    end

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] v);
        return (SIGNED != 0) ? {v[DATA_W-1], v} : {1'b0, v};
    endfunction

    assign last_beat = (beat == BW'(BEATS - 1));

    // Merge this beat's lanes, in ascending index order, into the running (best, second) pair.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        nb_val = best_val;
        nb_idx = best_idx;
        ns_val = sec_val;
        ns_idx = sec_idx;
        ns_vld = sec_vld;
        ci     = '0;
        cv     = '0;
        for (int l = 0; l < LANES; l++) begin
            ci = base + PW'(l);
            cv = padded[ci];
            if (int'(ci) < NUM_CLASSES && ci != '0) begin
                if (gt(cv, nb_val)) begin
                    ns_val = nb_val;
                    ns_idx = nb_idx;
                    ns_vld = 1'b1;
                    nb_val = cv;
                    nb_idx = IDX_W'(ci);
                end else if (!ns_vld || gt(cv, ns_val)) begin
                    ns_val = cv;
                    ns_idx = IDX_W'(ci);
                    ns_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples the pre-edge values of its neighbours.
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            max_val    <= '0;
            second_idx <= '0;
            margin     <= '0;
            base       <= '0;
            beat       <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            sec_val    <= '0;
            sec_idx    <= '0;
            sec_vld    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        base     <= '0;
                        beat     <= '0;
                        best_val <= arr[0];
                        best_idx <= '0;
                        sec_vld  <= 1'b0;
                    end
                end
                SCAN: begin
                    best_val <= nb_val;
                    best_idx <= nb_idx;
                    sec_val  <= ns_val;
                    sec_idx  <= ns_idx;
                    sec_vld  <= ns_vld;
                    base     <= base + PW'(LANES);
                    beat     <= beat + 1'b1;
                    if (last_beat) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        result     <= nb_idx;
                        max_val    <= nb_val;
                        second_idx <= ns_idx;
                        margin     <= ext(nb_val) - ext(ns_val);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fc_argmax_topk2.md
Name: fc_argmax_topk2

Overview:
- Parametrised argmax classifier for the FC output stage.
- Scans NUM_CLASSES scores, LANES scores per cycle, in signed or unsigned mode.
- Reports the winning index and value, plus the runner-up index and the confidence margin (max minus runner-up).
- Start/busy/done handshake; sits between the final FC layer and the result register/host interface.

Parameters:
- NUM_CLASSES, 10: number of scores; must be at least 2.
- DATA_W, 16: score width.
- LANES, 1: scores compared per cycle; 1 to NUM_CLASSES.
- SIGNED, 1: 1 selects two's-complement compare; 0 selects unsigned compare.
- IDX_W, $clog2(NUM_CLASSES): index width (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  begin a scan; sampled only in IDLE or DONE.
- arr  in  DATA_W x NUM_CLASSES (unpacked [0:NUM_CLASSES-1])  scores; must be held stable from the start edge until done.
- busy  out  1  high while scanning.
- done  out  1  level; high from scan completion until the next accepted start.
- result  out  IDX_W  index of the maximum score.
- max_val  out  DATA_W  maximum score.
- second_idx  out  IDX_W  index of the runner-up score.
- margin  out  DATA_W+1  max_val minus runner-up value; unsigned, never negative.

Behaviour:
- Reset: when reset_n=0 at a posedge, go to IDLE and clear busy, done, result, max_val, second_idx and margin to 0. Reset overrides everything, including during a scan.
- States: IDLE, SCAN, DONE.
- Beat count: BEATS = ceil(NUM_CLASSES/LANES). A beat counter steps the base index by LANES each cycle.
- IDLE or DONE with start=1: enter SCAN, set busy=1, clear done. Initialise the running best to {arr[0], idx 0} and the running second to "empty".
- SCAN: each cycle, merge lanes base..base+LANES-1 into the running (best, second) pair.
  - Lanes with index >= NUM_CLASSES are masked (padding) and never win.
  - Index 0 is compared against itself only as the initial best and is not double-counted.
- Merge rule: take candidates in ascending index order and use strict greater-than against best.
  - A candidate equal to best does not displace it, so on ties the lowest index wins best.
  - A displaced best becomes second.
  - A non-winning candidate replaces second if second is empty or the candidate is strictly greater than second.
  - Result: second is the highest value excluding the best's index, with lowest index on ties.
- Last beat: at the edge completing beat BEATS, register result, max_val, second_idx and margin; set done=1 and busy=0; enter DONE.
  - Latency: done is high exactly BEATS cycles after the edge that sampled start.
- Compare: with SIGNED=1 use $signed on both operands; with SIGNED=0 compare unsigned.
- Margin: sign- or zero-extend both operands to DATA_W+1 bits, then subtract. Full range fits (e.g. 0x7FFF - 0x8000 signed = 65535).
- Start while in SCAN: ignored; the scan continues undisturbed.
- Start while in DONE: restarts. done falls and busy rises at that edge; the previous outputs hold until overwritten at the end of the new scan.
- Outputs change only at scan completion or reset.
- start and reset_n both asserted: reset wins.

Test Plan:
- N=10, L=1, SIGNED=1, arr={5,-3,100,7,0,0,0,0,0,99}, start pulse → busy for 10 cycles, done at start edge+10; result=2, max_val=100, second_idx=9, margin=1.
- arr[0]=16'h7FFF, arr[3]=16'h8000, rest 0: SIGNED=1 → result=0, second_idx=1 (0, lowest index), margin=32767; SIGNED=0 → result=3, second_idx=0, margin=1.
- All scores 42 → result=0, max_val=42, second_idx=1, margin=0; all scores -5 (signed) → result=0, second_idx=1, margin=0.
- L=3, N=10: arr[9]=500, arr[4]=499, rest -1 → done exactly 4 cycles after start; result=9, second_idx=4, margin=1; padding lanes 10 and 11 never selected.
- Drive reset_n=0 during SCAN beat 2 → next edge busy=0, done=0, all outputs 0, state IDLE. A start pulse mid-SCAN (no reset) leaves the done time and results unchanged.
- In DONE, pulse start with new arr={1,2,3,4,5,6,7,8,9,10} → done drops the next cycle, old results hold until completion, then result=9, second_idx=8, margin=1.
